// File: rtl/sm_regport_arbiter.sv
// sm_regport_arbiter
// Shares the CPU register debug read port (regAddr_o / regData_i) between
// two requesters: requester 0 (VGA debug screen) and requester 1 (e.g. a
// serial register dumper). Each requester uses a req/ack handshake; reads
// are arbitrated round-robin. The granted address is held on regAddr_o for
// RD_LAT full cycles before regData_i is captured and returned with a
// one-cycle ack pulse.
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        asynchronous active-high reset
//   req0_i       requester 0 read request (hold with addr0_i until ack0_o)
//   addr0_i      requester 0 register address
//   ack0_o       one-cycle pulse, rdata0_o valid
//   rdata0_o     requester 0 read data (held between acks)
//   req1_i       requester 1 read request (hold with addr1_i until ack1_o)
//   addr1_i      requester 1 register address
//   ack1_o       one-cycle pulse, rdata1_o valid
//   rdata1_o     requester 1 read data (held between acks)
//   regAddr_o    address to the CPU register debug port
//   regData_i    data from the CPU register debug port
//   busy_o       high while a read is in flight
//   gnt_o        one-hot owner of the in-flight read, 0 when idle
//
// RD_LAT must lie in 1..15 (it is loaded into a 4-bit settle counter).
module sm_regport_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] regAddr_o,
  input  logic [DATA_W-1:0] regData_i,
  output logic              busy_o,
  output logic [1:0]        gnt_o
);

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                last_q;
  logic [1:0]          gnt_q;
  logic                busy_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [ADDR_W-1:0]   reg_addr_q;

  // A requester whose ack is high this cycle is still holding req from the
  // finished read; masking it stops the same read being served twice.
  logic                eff0_d;
  logic                eff1_d;
  logic                grant_d;
  logic                win_d;

  assign eff0_d  = req0_i & ~ack0_q;
  assign eff1_d  = req1_i & ~ack1_q;
  assign grant_d = eff0_d | eff1_d;
  // On contention the requester that did not win last time gets the port.
  assign win_d   = (eff0_d & eff1_d) ? ~last_q : eff1_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;  // requester 0 wins the first contended grant
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      reg_addr_q <= '0;
    end else begin
      // Acks are single-cycle pulses.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            reg_addr_q <= win_d ? addr1_i : addr0_i;
            gnt_q      <= win_d ? 2'b10 : 2'b01;
            last_q     <= win_d;
            cnt_q      <= RD_LAT_C;
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (gnt_q[1]) begin
              rdata1_q <= regData_i;
              ack1_q   <= 1'b1;
            end else begin
              rdata0_q <= regData_i;
              ack0_q   <= 1'b1;
            end
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign regAddr_o = reg_addr_q;
  assign busy_o    = busy_q;
  assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_sm_regport_arbiter.sv
// Directed bench for sm_regport_arbiter: instance A uses RD_LAT=1 with an
// immediate register-file model, instance B uses RD_LAT=4 with a register
// file whose output only settles some cycles after the address changes.
module tb_sm_regport_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- instance A (RD_LAT = 1) ----------------
  logic        rst_a, req0_a, req1_a, ack0_a, ack1_a, busy_a;
  logic [4:0]  addr0_a, addr1_a, regAddr_a;
  logic [31:0] rdata0_a, rdata1_a, regData_a;
  logic [1:0]  gnt_a;

  assign regData_a = (regAddr_a == 5'd3) ? 32'hDEADBEEF
                                         : (32'hC0DE0000 | {27'd0, regAddr_a});

  sm_regport_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .req0_i(req0_a), .addr0_i(addr0_a), .ack0_o(ack0_a), .rdata0_o(rdata0_a),
    .req1_i(req1_a), .addr1_i(addr1_a), .ack1_o(ack1_a), .rdata1_o(rdata1_a),
    .regAddr_o(regAddr_a), .regData_i(regData_a),
    .busy_o(busy_a), .gnt_o(gnt_a)
  );

  // ---------------- instance B (RD_LAT = 4) ----------------
  logic        rst_b, req0_b, req1_b, ack0_b, ack1_b, busy_b;
  logic [4:0]  addr0_b, addr1_b, regAddr_b;
  logic [31:0] rdata0_b, rdata1_b, regData_b;
  logic [1:0]  gnt_b;

  // Slow register file: shows garbage until the address has been seen
  // unchanged for a cycle, i.e. the value settles 2 cycles after a change.
  logic [4:0]  seen_addr_b = 5'd0;
  int          age_b = 1;
  always @(posedge clk) begin
    if (regAddr_b != seen_addr_b) begin
      seen_addr_b <= regAddr_b;
      age_b       <= 0;
    end else if (age_b < 3) begin
      age_b <= age_b + 1;
    end
  end
  assign regData_b = (age_b >= 1) ? (32'h5E770000 | {27'd0, seen_addr_b})
                                  : 32'hBADBAD00;

  sm_regport_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .req0_i(req0_b), .addr0_i(addr0_b), .ack0_o(ack0_b), .rdata0_o(rdata0_b),
    .req1_i(req1_b), .addr1_i(addr1_b), .ack1_o(ack1_b), .rdata1_o(rdata1_b),
    .regAddr_o(regAddr_b), .regData_i(regData_b),
    .busy_o(busy_b), .gnt_o(gnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  tab0 [5];
  logic [4:0]  tab1 [5];
  logic [31:0] dat0 [5];
  logic [31:0] dat1 [5];
  logic [4:0]  bb_addr [3];
  logic [31:0] bb_dat  [3];

  initial begin
    tab0 = '{5'd1, 5'd0, 5'd7, 5'd31, 5'd3};
    dat0 = '{32'hC0DE0001, 32'hC0DE0000, 32'hC0DE0007, 32'hC0DE001F, 32'hDEADBEEF};
    tab1 = '{5'd2, 5'd5, 5'd30, 5'd9, 5'd16};
    dat1 = '{32'hC0DE0002, 32'hC0DE0005, 32'hC0DE001E, 32'hC0DE0009, 32'hC0DE0010};
    bb_addr = '{5'd4, 5'd5, 5'd6};
    bb_dat  = '{32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006};

    rst_a = 1'b1; rst_b = 1'b1;
    req0_a = 1'b0; req1_a = 1'b0; addr0_a = 5'd0; addr1_a = 5'd0;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = 5'd0; addr1_b = 5'd0;

    // ---- reset state ----
    #12;
    chk("rst_ack0",    32'(ack0_a),    32'd0);
    chk("rst_ack1",    32'(ack1_a),    32'd0);
    chk("rst_rdata0",  rdata0_a,       32'd0);
    chk("rst_rdata1",  rdata1_a,       32'd0);
    chk("rst_regaddr", 32'(regAddr_a), 32'd0);
    chk("rst_gnt",     32'(gnt_a),     32'd0);
    chk("rst_busy",    32'(busy_a),    32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // ---- single read on A, RD_LAT=1 ----
    tick();
    req0_a = 1'b1; addr0_a = 5'd3;
    tick();  // grant edge
    chk("s_regaddr", 32'(regAddr_a), 32'd3);
    chk("s_gnt",     32'(gnt_a),     32'b01);
    chk("s_busy",    32'(busy_a),    32'd1);
    chk("s_ack0_early", 32'(ack0_a), 32'd0);
    tick();  // capture edge
    chk("s_ack0",   32'(ack0_a), 32'd1);
    chk("s_rdata0", rdata0_a,    32'hDEADBEEF);
    chk("s_ack1",   32'(ack1_a), 32'd0);
    chk("s_busy_done", 32'(busy_a), 32'd0);
    req0_a = 1'b0;
    tick();
    chk("s_ack0_pulse", 32'(ack0_a), 32'd0);
    chk("s_rdata0_hold", rdata0_a,   32'hDEADBEEF);

    // ---- simultaneous start after reset, then continuous contention ----
    rst_a = 1'b1;
    #1;
    chk("r2_rdata0", rdata0_a, 32'd0);
    rst_a = 1'b0;
    req0_a = 1'b1; addr0_a = tab0[0];
    req1_a = 1'b1; addr1_a = tab1[0];
    for (int i = 0; i < 10; i++) begin
      int w;
      int k;
      w = i % 2;
      k = i / 2;
      tick();
      chk($sformatf("c%0d_gnt", i), 32'(gnt_a), (w == 1) ? 32'b10 : 32'b01);
      chk($sformatf("c%0d_regaddr", i), 32'(regAddr_a),
          (w == 1) ? 32'(tab1[k]) : 32'(tab0[k]));
      tick();
      chk($sformatf("c%0d_ack0", i), 32'(ack0_a), (w == 0) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d_ack1", i), 32'(ack1_a), (w == 1) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d_rdata", i), (w == 1) ? rdata1_a : rdata0_a,
          (w == 1) ? dat1[k] : dat0[k]);
      if (k < 4) begin
        if (w == 1) addr1_a = tab1[k+1];
        else        addr0_a = tab0[k+1];
      end else begin
        if (w == 1) req1_a = 1'b0;
        else        req0_a = 1'b0;
      end
    end
    tick();
    chk("c_end_busy",   32'(busy_a), 32'd0);
    chk("c_end_gnt",    32'(gnt_a),  32'd0);
    chk("c_end_ack1",   32'(ack1_a), 32'd0);
    chk("c_end_rdata0", rdata0_a,    32'hDEADBEEF);

    // ---- back-to-back reads from requester 1 on A ----
    req1_a = 1'b1; addr1_a = bb_addr[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("b%0d_gnt", k),     32'(gnt_a),     32'b10);
      chk($sformatf("b%0d_regaddr", k), 32'(regAddr_a), 32'(bb_addr[k]));
      tick();
      chk($sformatf("b%0d_ack1", k),    32'(ack1_a),    32'd1);
      chk($sformatf("b%0d_rdata1", k),  rdata1_a,       bb_dat[k]);
      if (k < 2) addr1_a = bb_addr[k+1];
      else       req1_a = 1'b0;
      tick();  // the acked request is masked: one idle cycle
      chk($sformatf("b%0d_gap_ack1", k), 32'(ack1_a), 32'd0);
      chk($sformatf("b%0d_gap_busy", k), 32'(busy_a), 32'd0);
    end

    // ---- RD_LAT=4 on B with a slowly settling register file ----
    req0_b = 1'b1; addr0_b = 5'd9;
    tick();  // grant edge
    chk("l4_regaddr", 32'(regAddr_b), 32'd9);
    chk("l4_busy",    32'(busy_b),    32'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("l4_wait%0d_ack0", j), 32'(ack0_b), 32'd0);
    end
    tick();  // capture edge, 4 edges after grant
    chk("l4_ack0",   32'(ack0_b), 32'd1);
    chk("l4_rdata0", rdata0_b,    32'h5E770009);
    req0_b = 1'b0;
    tick();
    chk("l4_ack0_pulse", 32'(ack0_b), 32'd0);

    // ---- asynchronous reset while B is in WAIT ----
    req1_b = 1'b1; addr1_b = 5'd12;
    tick();
    chk("rw_busy", 32'(busy_b), 32'd1);
    chk("rw_gnt",  32'(gnt_b),  32'b10);
    tick();
    #2;
    rst_b = 1'b1;
    #1;
    chk("rw_ack0",    32'(ack0_b),    32'd0);
    chk("rw_ack1",    32'(ack1_b),    32'd0);
    chk("rw_gnt0",    32'(gnt_b),     32'd0);
    chk("rw_busy0",   32'(busy_b),    32'd0);
    chk("rw_regaddr", 32'(regAddr_b), 32'd0);
    chk("rw_rdata0",  rdata0_b,       32'd0);
    chk("rw_rdata1",  rdata1_b,       32'd0);
    req1_b = 1'b0;
    #2;
    rst_b = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("rw_post%0d_ack1", j), 32'(ack1_b), 32'd0);
      chk($sformatf("rw_post%0d_busy", j), 32'(busy_b), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
